// File: rtl/reg_file_2w2r.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_2w2r
// Purpose  : Two-write / two-read register file with port-1 write priority,
//            optional write-to-read bypass, valid tracking and error flags.
// Revision : 1.0
// ============================================================================
module reg_file_2w2r #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we0,
   input  logic [ADDR_W-1:0] waddr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] waddr1,
   input  logic [DATA_W-1:0] wdata1,
   input  logic              re0,
   input  logic [ADDR_W-1:0] raddr0,
   output logic [DATA_W-1:0] rdata0,
   output logic              rvalid0,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   output logic              rvalid1,
   output logic [DEPTH-1:0]  valid_mask,
   output logic              collision,
   output logic [7:0]        collision_count,
   output logic              err
);

   // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  r_valid;
   logic [DATA_W-1:0] r_rdata0;
   logic [DATA_W-1:0] r_rdata1;
   logic              r_rvalid0;
   logic              r_rvalid1;
   logic              r_coll;
   logic [7:0]        r_coll_cnt;
   logic              r_err;

   logic              w_wr0_ok;
   logic              w_wr1_ok;
   logic              w_wr0_oor;
   logic              w_wr1_oor;
   logic              w_coll;
   logic [DATA_W:0]   w_rd0;
   logic [DATA_W:0]   w_rd1;

   assign w_wr0_ok  = we0 && ({1'b0, waddr0} < c_DEPTH);
   assign w_wr1_ok  = we1 && ({1'b0, waddr1} < c_DEPTH);
   assign w_wr0_oor = we0 && !w_wr0_ok;
   assign w_wr1_oor = we1 && !w_wr1_ok;
   assign w_coll    = w_wr0_ok && w_wr1_ok && (waddr0 == waddr1);

   // Returns {error, data}; error marks an out-of-range or unwritten read.
   function automatic logic [DATA_W:0] f_read(input logic [ADDR_W-1:0] a);
      if ({1'b0, a} >= c_DEPTH)
         return {1'b1, {DATA_W{1'b0}}};
      if ((BYPASS != 0) && w_wr1_ok && (waddr1 == a))
         return {1'b0, wdata1};
      if ((BYPASS != 0) && w_wr0_ok && (waddr0 == a))
         return {1'b0, wdata0};
      if (r_valid[a])
         return {1'b0, r_mem[a]};
      return {1'b1, {DATA_W{1'b0}}};
   endfunction

   always_comb begin
      w_rd0 = f_read(raddr0);
      w_rd1 = f_read(raddr1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_valid    <= '0;
         r_rdata0   <= '0;
         r_rdata1   <= '0;
         r_rvalid0  <= 1'b0;
         r_rvalid1  <= 1'b0;
         r_coll     <= 1'b0;
         r_coll_cnt <= 8'd0;
         r_err      <= 1'b0;
      end else begin
         // Port 1 is checked first so it wins a same-address collision.
         for (int i = 0; i < DEPTH; i++) begin
            if (w_wr1_ok && (waddr1 == ADDR_W'(i))) begin
               r_mem[i]   <= wdata1;
               r_valid[i] <= 1'b1;
            end else if (w_wr0_ok && (waddr0 == ADDR_W'(i))) begin
               r_mem[i]   <= wdata0;
               r_valid[i] <= 1'b1;
            end
         end
         if (re0) begin
            r_rdata0 <= w_rd0[DATA_W-1:0];
         end
         if (re1) begin
            r_rdata1 <= w_rd1[DATA_W-1:0];
         end
         r_rvalid0 <= re0;
         r_rvalid1 <= re1;
         r_coll    <= w_coll;
         if (w_coll && (r_coll_cnt != 8'hFF)) begin
            r_coll_cnt <= r_coll_cnt + 8'd1;
         end
         r_err <= w_wr0_oor | w_wr1_oor | (re0 & w_rd0[DATA_W]) | (re1 & w_rd1[DATA_W]);
      end
   end

   assign rdata0          = r_rdata0;
   assign rdata1          = r_rdata1;
   assign rvalid0         = r_rvalid0;
   assign rvalid1         = r_rvalid1;
   assign valid_mask      = r_valid;
   assign collision       = r_coll;
   assign collision_count = r_coll_cnt;
   assign err             = r_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_2w2r.sv
`default_nettype none
// Scoreboard bench: two register files (DEPTH 8 bypass, DEPTH 6 no bypass) share
// stimulus; an array-level model queues per-cycle expectations checked by monitors.
module tb_reg_file_2w2r;

   typedef struct {
      int          due;
      logic [15:0] rd0;
      logic [15:0] rd1;
      logic        rv0;
      logic        rv1;
      logic        err;
      logic        coll;
      logic [7:0]  cnt;
      logic [7:0]  mask;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we0 = 1'b0, we1 = 1'b0, re0 = 1'b0, re1 = 1'b0;
   logic [2:0]  waddr0 = '0, waddr1 = '0, raddr0 = '0, raddr1 = '0;
   logic [15:0] wdata0 = '0, wdata1 = '0;

   logic [15:0] a_rd0, a_rd1, b_rd0, b_rd1;
   logic        a_rv0, a_rv1, b_rv0, b_rv1;
   logic [7:0]  a_mask;
   logic [5:0]  b_mask;
   logic        a_coll, b_coll, a_err, b_err;
   logic [7:0]  a_cnt, b_cnt;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   exp_t sq0[$];
   exp_t sq1[$];

   logic [15:0] mmem [2][8];
   bit          mwr  [2][8];
   logic [15:0] mrd0 [2];
   logic [15:0] mrd1 [2];
   int          mcnt [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   reg_file_2w2r #(.DATA_W(16), .DEPTH(8), .ADDR_W(3), .BYPASS(1)) u_a (
      .clk(clk), .rst(rst),
      .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
      .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
      .re0(re0), .raddr0(raddr0), .rdata0(a_rd0), .rvalid0(a_rv0),
      .re1(re1), .raddr1(raddr1), .rdata1(a_rd1), .rvalid1(a_rv1),
      .valid_mask(a_mask), .collision(a_coll), .collision_count(a_cnt), .err(a_err)
   );

   reg_file_2w2r #(.DATA_W(16), .DEPTH(6), .ADDR_W(3), .BYPASS(0)) u_b (
      .clk(clk), .rst(rst),
      .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
      .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
      .re0(re0), .raddr0(raddr0), .rdata0(b_rd0), .rvalid0(b_rv0),
      .re1(re1), .raddr1(raddr1), .rdata1(b_rd1), .rvalid1(b_rv1),
      .valid_mask(b_mask), .collision(b_coll), .collision_count(b_cnt), .err(b_err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // {error, data}: what a read of address a should return this cycle.
   function automatic logic [16:0] lookup(input int k, input int d, input bit byp,
                                          input logic [2:0] a,
                                          input logic [15:0] nm [8], input bit wt [8]);
      if (int'(a) >= d)  return {1'b1, 16'h0000};
      if (byp && wt[a])  return {1'b0, nm[a]};
      if (mwr[k][a])     return {1'b0, mmem[k][a]};
      return {1'b1, 16'h0000};
   endfunction

   task automatic model(input int k);
      exp_t        e;
      int          d;
      bit          byp;
      logic [15:0] nm [8];
      bit          wt [8];
      logic [16:0] r;
      d   = (k == 0) ? 8 : 6;
      byp = (k == 0);
      e   = '{default: 0};
      e.due = cyc + 1;
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            mmem[k][i] = '0;
            mwr[k][i]  = 1'b0;
         end
         mrd0[k] = '0;
         mrd1[k] = '0;
         mcnt[k] = 0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            nm[i] = mmem[k][i];
            wt[i] = 1'b0;
         end
         if (we0) begin
            if (int'(waddr0) < d) begin nm[waddr0] = wdata0; wt[waddr0] = 1'b1; end
            else e.err = 1'b1;
         end
         if (we1) begin
            if (int'(waddr1) < d) begin nm[waddr1] = wdata1; wt[waddr1] = 1'b1; end
            else e.err = 1'b1;
         end
         if (we0 && we1 && waddr0 == waddr1 && int'(waddr0) < d) begin
            e.coll = 1'b1;
            if (mcnt[k] < 255) mcnt[k]++;
         end
         if (re0) begin
            r = lookup(k, d, byp, raddr0, nm, wt);
            mrd0[k] = r[15:0];
            if (r[16]) e.err = 1'b1;
         end
         if (re1) begin
            r = lookup(k, d, byp, raddr1, nm, wt);
            mrd1[k] = r[15:0];
            if (r[16]) e.err = 1'b1;
         end
         for (int i = 0; i < 8; i++) begin
            mmem[k][i] = nm[i];
            mwr[k][i]  = mwr[k][i] | wt[i];
         end
         e.rv0 = re0;
         e.rv1 = re1;
      end
      e.rd0 = mrd0[k];
      e.rd1 = mrd1[k];
      e.cnt = 8'(mcnt[k]);
      for (int i = 0; i < d; i++) e.mask[i] = mwr[k][i];
      if (k == 0) sq0.push_back(e);
      else        sq1.push_back(e);
   endtask

   task automatic compare(input string p, input exp_t e,
                          input logic [15:0] rd0, input logic [15:0] rd1,
                          input logic rv0, input logic rv1, input logic er,
                          input logic co, input logic [7:0] cn, input logic [7:0] mk);
      chk({p, ".rvalid0"}, 32'(rv0), 32'(e.rv0));
      chk({p, ".rvalid1"}, 32'(rv1), 32'(e.rv1));
      chk({p, ".rdata0"}, 32'(rd0), 32'(e.rd0));
      chk({p, ".rdata1"}, 32'(rd1), 32'(e.rd1));
      chk({p, ".err"}, 32'(er), 32'(e.err));
      chk({p, ".collision"}, 32'(co), 32'(e.coll));
      chk({p, ".collision_count"}, 32'(cn), 32'(e.cnt));
      chk({p, ".valid_mask"}, 32'(mk), 32'(e.mask));
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (sq0.size() > 0 && sq0[0].due <= cyc) begin
         e = sq0.pop_front();
         if (e.due < cyc) chk("a.stale_expectation", 32'(cyc), 32'(e.due));
         else compare("a", e, a_rd0, a_rd1, a_rv0, a_rv1, a_err, a_coll, a_cnt, a_mask);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      while (sq1.size() > 0 && sq1[0].due <= cyc) begin
         e = sq1.pop_front();
         if (e.due < cyc) chk("b.stale_expectation", 32'(cyc), 32'(e.due));
         else compare("b", e, b_rd0, b_rd1, b_rv0, b_rv1, b_err, b_coll, b_cnt, {2'b00, b_mask});
      end
   end

   task automatic drive(input logic r,
                        input logic w0, input logic [2:0] a0, input logic [15:0] d0,
                        input logic w1, input logic [2:0] a1, input logic [15:0] d1,
                        input logic e0, input logic [2:0] ra0,
                        input logic e1, input logic [2:0] ra1);
      @(posedge clk);
      #1;
      rst = r;
      we0 = w0; waddr0 = a0; wdata0 = d0;
      we1 = w1; waddr1 = a1; wdata1 = d1;
      re0 = e0; raddr0 = ra0;
      re1 = e1; raddr1 = ra1;
      model(0);
      model(1);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      logic [2:0] a;
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // Unwritten read right after reset.
      drive(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
      drive(0, 1, 3, 16'hA5A5, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
      // Collision then read-back, then saturate the counter.
      drive(0, 1, 5, 16'h1111, 1, 5, 16'h2222, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
      for (int i = 0; i < 300; i++)
         drive(0, 1, 5, 16'(i), 1, 5, 16'(i + 1000), 0, 0, 0, 0);
      idle();
      // Same-cycle write/read: address 6 (in range only for u_a) and address 4.
      drive(0, 1, 6, 16'h0042, 1, 4, 16'h0042, 0, 0, 0, 0);
      drive(0, 1, 6, 16'hBEEF, 1, 4, 16'hBEEF, 1, 6, 1, 4);
      idle();
      // Out-of-range write for both, then read of address 6.
      drive(0, 1, 7, 16'h7777, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0);
      idle();
      for (int i = 0; i < 8; i++) drive(0, 1, 3'(i), 16'(i * 3 + 1), 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 1, 0, 16'hFFFF, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      idle();
      for (int i = 0; i < 3000; i++) begin
         a = 3'($urandom_range(0, 7));
         drive(($urandom_range(0, 63) == 0),
               1'($urandom), 3'($urandom_range(0, 7)), 16'($urandom),
               1'($urandom), ($urandom_range(0, 3) == 0) ? a : 3'($urandom_range(0, 7)),
               16'($urandom),
               1'($urandom), ($urandom_range(0, 3) == 0) ? a : 3'($urandom_range(0, 7)),
               1'($urandom), 3'($urandom_range(0, 7)));
      end
      idle();
      for (int i = 0; i < 10 && (sq0.size() > 0 || sq1.size() > 0); i++) @(negedge clk);
      #1;
      chk("drain.a", 32'(sq0.size()), 32'd0);
      chk("drain.b", 32'(sq1.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/reg_file_2w2r.md
Name: reg_file_2w2r

Overview:
Parametrised multi-port register file and the successor to the team's single-register, two-source storage block. Provides DEPTH entries of DATA_W bits, two write ports with fixed priority, and two independently registered read ports. Adds optional same-cycle write-to-read bypass, per-entry valid tracking and write-collision bookkeeping. Used as general scratch storage by datapath blocks in the assignment designs.

Parameters:
DATA_W, 16, width of each entry and of all data ports
DEPTH, 8, number of entries (2..256; need not be a power of two)
ADDR_W, 3, address width; must satisfy 2**ADDR_W >= DEPTH
BYPASS, 1, 1 = a read returns data written in the same cycle; 0 = a read returns the pre-write contents

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
we0  input  1  write enable, port 0
waddr0  input  ADDR_W  write address, port 0
wdata0  input  DATA_W  write data, port 0
we1  input  1  write enable, port 1 (priority port)
waddr1  input  ADDR_W  write address, port 1
wdata1  input  DATA_W  write data, port 1
re0  input  1  read enable, port 0
raddr0  input  ADDR_W  read address, port 0
rdata0  output  DATA_W  registered read data, port 0
rvalid0  output  1  one-cycle pulse marking rdata0 as updated
re1  input  1  read enable, port 1
raddr1  input  ADDR_W  read address, port 1
rdata1  output  DATA_W  registered read data, port 1
rvalid1  output  1  one-cycle pulse marking rdata1 as updated
valid_mask  output  DEPTH  bit i = 1 once entry i has been written since reset
collision  output  1  one-cycle pulse: both ports wrote the same address in the previous cycle
collision_count  output  8  saturating count of collisions
err  output  1  one-cycle pulse: previous cycle had an out-of-range access or a read of an unwritten entry

Behaviour:
- Reset: rst is sampled at clk. It clears all entries, valid_mask, rdata0/1, rvalid0/1, collision, collision_count and err to 0. Reset beats every write and read in the same cycle; no access is recorded.
- Write: each port with weN=1 and waddrN<DEPTH writes wdataN at the edge and sets valid_mask[waddrN]. The new value is visible to reads from the next cycle onward.
- Write collision (we0=we1=1, waddr0==waddr1, in range):
  - port 1 data is stored; port 0 is dropped;
  - collision=1 in the next cycle;
  - collision_count increments and holds at 255.
- Read: latency 1. If reN=1, rdataN is loaded at the edge and rvalidN=1 in the following cycle. If reN=0, rdataN holds its last value and rvalidN=0. The two read ports are fully independent and may use the same address.
- Bypass, BYPASS=1: if a read address matches an in-range write address in the same cycle, rdataN returns the write data. If both ports write that address, port 1 data is returned. Such a read is never counted as an unwritten read.
- Bypass, BYPASS=0: the same situation returns the old entry contents.
- Unwritten read: reading an entry whose valid bit is 0 (and which is not bypassed) returns 0 and raises err next cycle.
- Out of range (address >= DEPTH):
  - write: ignored, no state change;
  - read: returns 0 with rvalidN=1;
  - either case raises err next cycle.
- err: a single OR-ed pulse covering all error sources from the previous cycle.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset, then re0=1 raddr0=2 -> next cycle rdata0=0, rvalid0=1, err=1, valid_mask=8'h00.
- we0=1 waddr0=3 wdata0=16'hA5A5; next cycle re1=1 raddr1=3 -> rdata1=16'hA5A5 one cycle later, valid_mask[3]=1, err=0.
- we0=1 waddr0=5 wdata0=16'h1111 and we1=1 waddr1=5 wdata1=16'h2222 in the same cycle:
  - entry 5 = 16'h2222, collision pulses once, collision_count=1;
  - 300 such collisions -> collision_count=255.
- Same-cycle write 16'hBEEF to address 6 with re0 raddr0=6, entry 6 previously holding 16'h0042:
  - BYPASS=1 -> rdata0=16'hBEEF;
  - BYPASS=0 -> rdata0=16'h0042.
- DEPTH=6: we0=1 waddr0=7, and separately re0=1 raddr0=6 -> write ignored, rdata0=0, rvalid0=1, err pulses each time, valid_mask unchanged.
- Entries 0..7 written; assert rst together with we1=1 waddr1=0 wdata1=16'hFFFF -> all entries 0, valid_mask=0, collision_count=0; a read of entry 0 afterwards returns 0 with err=1.
